// File: rtl/register_pkg.sv
// Shared types for the shadow-flag save/restore unit: FSM state encoding and the
// {x,y} flag pair held on the LIFO.
package register_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RESTORE = 1'b1
  } shadow_state_t;

  typedef struct packed {
    logic x;
    logic y;
  } flag_pair_t;

endpackage

// File: rtl/register_shadow_lifo.sv
// DEPTH-entry LIFO of flag pairs with occupancy count; push/pop are ignored when
// full/empty respectively so the pointer never wraps.
module register_shadow_lifo
  import register_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          notReset,
  input  logic          i_push,
  input  logic          i_pop,
  input  flag_pair_t    i_data,
  output flag_pair_t    o_top,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  flag_pair_t    r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_top_ptr;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_top_idx;
  logic          w_push;
  logic          w_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push    = i_push & ~o_full;
  assign w_pop     = i_pop & ~o_empty;
  assign w_top_ptr = r_count - CW'(1);
  assign w_wr_idx  = r_count[AW-1:0];
  assign w_top_idx = w_top_ptr[AW-1:0];
  assign o_top     = r_mem[w_top_idx];
  assign o_count   = r_count;

  // Storage is intentionally not reset; only Count defines valid entries.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/register_shadow_flags.sv
// Shadow-flag save/restore unit: pushes {F_X,F_Y} on exception entry and, on
// return, pops the pair and drives a one-cycle restore strobe to the flag bank.
module register_shadow_flags
  import register_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          notReset,
  input  logic          F_X,
  input  logic          F_Y,
  input  logic          Ex_Enter,
  input  logic          Ex_Return,
  output logic          notShadowF_X,
  output logic          notShadowF_Y,
  output logic          PR_Ex,
  output logic          notPR_Ex,
  output logic          Ack,
  output logic          Busy,
  output logic [CW-1:0] Count,
  output logic          Overflow,
  output logic          Underflow
);

  shadow_state_t r_state;
  shadow_state_t w_state_nxt;
  logic          r_ns_x;
  logic          r_ns_y;
  logic          r_uf_ack;
  logic          r_overflow;
  logic          r_underflow;
  flag_pair_t    w_push_data;
  flag_pair_t    w_top;
  logic          w_full;
  logic          w_empty;
  logic          w_idle;
  logic          w_ret_acc;
  logic          w_pop;
  logic          w_uf;
  logic          w_ovf;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_push_data = '{x: F_X, y: F_Y};

  // A pending underflow Ack blocks re-acceptance of the still-held return level.
  assign w_ret_acc = w_idle & Ex_Return & ~Ex_Enter & ~r_uf_ack;
  assign w_pop     = w_ret_acc & ~w_empty;
  assign w_uf      = w_ret_acc & w_empty;
  assign w_ovf     = Ex_Enter & w_full;

  register_shadow_lifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_lifo (
    .Clk      (Clk),
    .notReset (notReset),
    .i_push   (Ex_Enter),
    .i_pop    (w_pop),
    .i_data   (w_push_data),
    .o_top    (w_top),
    .o_count  (Count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_pop) w_state_nxt = ST_RESTORE;
      ST_RESTORE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      r_ns_x      <= 1'b1;
      r_ns_y      <= 1'b1;
      r_uf_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_ns_x <= ~w_top.x;
        r_ns_y <= ~w_top.y;
      end
      r_uf_ack <= w_uf;
      if (w_ovf) r_overflow <= 1'b1;
      if (w_uf)  r_underflow <= 1'b1;
    end
  end

  // Both strobe rails derive from the single state flop.
  assign PR_Ex        = (r_state == ST_RESTORE);
  assign notPR_Ex     = ~PR_Ex;
  assign Busy         = PR_Ex;
  assign Ack          = PR_Ex | r_uf_ack;
  assign notShadowF_X = r_ns_x;
  assign notShadowF_Y = r_ns_y;
  assign Overflow     = r_overflow;
  assign Underflow    = r_underflow;

endmodule
